// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding and
// word geometry used by the loader FSM and its byte assembler.
package program_loader_pkg;

    localparam logic [2:0] ST_HDR   = 3'd0;
    localparam logic [2:0] ST_BODY  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;

    typedef enum logic [2:0] {
        HDR   = ST_HDR,
        BODY  = ST_BODY,
        WRITE = ST_WRITE,
        DONE  = ST_DONE,
        ERROR = ST_ERROR
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory / core-control outputs of the
// program loader; slave is the loader side, master the host/bench side.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic               cpu_run;
    logic               busy;
    logic               err;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err
    );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Big-endian byte-to-word shifter. word_o already includes the byte being
// shifted this cycle, so the caller can act on a full word without waiting.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en_i,
    input  logic [7:0]         byte_i,
    input  logic               clear_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_full_o
);
    logic [INSTR_W-1:0] word_q, word_d;
    logic [1:0]         cnt_q, cnt_d;

    // Next shift-register value and byte count; full pulses on the last byte.
    always_comb begin
        word_d      = word_q;
        cnt_d       = cnt_q;
        word_o      = {word_q[INSTR_W-9:0], byte_i};
        word_full_o = 1'b0;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = 2'd0;
        end else if (shift_en_i) begin
            word_d      = {word_q[INSTR_W-9:0], byte_i};
            cnt_d       = cnt_q + 2'd1;
            word_full_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
        end else begin
            word_d = word_q;
        end
    end

    // Shift register and byte counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/program_loader.sv
// Boot loader: reads a big-endian word count then that many instruction
// words, writes them to instruction memory from address 0, then releases the core.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MAX_WORDS = 1024,
    parameter int ADDR_W    = 32
)
(
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus_if
);
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               cpu_run_q, cpu_run_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;

    logic               accept_s;
    logic               asm_clear_s;
    logic               word_full_s;
    logic [INSTR_W-1:0] asm_word_s;
    logic               hdr_bad_s;
    logic               last_s;

    assign accept_s    = bus_if.in_valid & in_ready_q;
    assign asm_clear_s = (state_q == DONE) || (state_q == ERROR);
    assign hdr_bad_s   = (asm_word_s == 32'd0) || (asm_word_s > 32'(MAX_WORDS));
    assign last_s      = ((idx_q + {{(ADDR_W-1){1'b0}}, 1'b1}) == count_q);

    byte_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .shift_en_i  (accept_s),
        .byte_i      (bus_if.in_data),
        .clear_i     (asm_clear_s),
        .word_o      (asm_word_s),
        .word_full_o (word_full_s)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_run_d   = cpu_run_q;
        busy_d      = busy_q;
        err_d       = err_q;
        case (state_q)
            HDR: begin
                if (word_full_s) begin
                    if (hdr_bad_s) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BODY;
                        busy_d  = 1'b1;
                        idx_d   = '0;
                        count_d = ADDR_W'(asm_word_s);
                    end
                end else begin
                    state_d = HDR;
                end
            end
            BODY: begin
                if (word_full_s) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q;
                    mem_wdata_d = asm_word_s;
                end else begin
                    state_d = BODY;
                end
            end
            WRITE: begin
                if (last_s) begin
                    state_d   = DONE;
                    cpu_run_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    state_d = BODY;
                    idx_d   = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_d   = DONE;
                cpu_run_d = 1'b1;
                busy_d    = 1'b0;
            end
            ERROR: begin
                state_d   = ERROR;
                err_d     = 1'b1;
                cpu_run_d = 1'b0;
                busy_d    = 1'b0;
            end
            default: begin
                // An illegal encoding is treated as a fault: never release the core.
                state_d   = ERROR;
                err_d     = 1'b1;
                cpu_run_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
        in_ready_d = (state_d == HDR) || (state_d == BODY);
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HDR;
            idx_q       <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_run_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_run_q   <= cpu_run_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus_if.in_ready  = in_ready_q;
    assign bus_if.mem_we    = mem_we_q;
    assign bus_if.mem_addr  = mem_addr_q;
    assign bus_if.mem_wdata = mem_wdata_q;
    assign bus_if.cpu_run   = cpu_run_q;
    assign bus_if.busy      = busy_q;
    assign bus_if.err       = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected memory writes are queued
// as bytes are sent and matched against each mem_we pulse.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int MAXW   = 1024;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

    program_loader #(.MAX_WORDS(MAXW), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int writes_seen  = 0;
    int unexpected   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe is matched against the oldest expected write.
    always @(negedge clk) begin
        if (reset && bus_if.mem_we) begin
            writes_seen++;
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                check_eq("wr_addr", bus_if.mem_addr, exp_e[63:32]);
                check_eq("wr_data", bus_if.mem_wdata, exp_e[31:0]);
            end else begin
                unexpected++;
            end
        end
    end

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        while (!bus_if.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            check_eq("ready_timeout", 32'(waited), 32'd0);
        end else begin
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd0);
        check_eq({tag, "_mem_we"},   32'(bus_if.mem_we), 32'd0);
        check_eq({tag, "_mem_addr"}, bus_if.mem_addr, 32'd0);
        check_eq({tag, "_mem_wdata"}, bus_if.mem_wdata, 32'd0);
        check_eq({tag, "_cpu_run"},  32'(bus_if.cpu_run), 32'd0);
        check_eq({tag, "_busy"},     32'(bus_if.busy), 32'd0);
        check_eq({tag, "_err"},      32'(bus_if.err), 32'd0);
    endtask

    initial begin
        int w0;
        logic [31:0] rw;
        reset = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // Two-word program, back-to-back bytes.
        w0 = writes_seen;
        push_exp(32'd0, 32'h12345678);
        push_exp(32'd1, 32'h9ABCDEF0);
        send_word(32'h0000_0002);
        check_eq("t1_busy_hdr", 32'(bus_if.busy), 32'd1);
        send_word(32'h1234_5678);
        send_word(32'h9ABC_DEF0);
        check_eq("t1_we2", 32'(bus_if.mem_we), 32'd1);
        check_eq("t1_run_in_write", 32'(bus_if.cpu_run), 32'd0);
        check_eq("t1_busy_in_write", 32'(bus_if.busy), 32'd1);
        @(negedge clk);
        check_eq("t1_run", 32'(bus_if.cpu_run), 32'd1);
        check_eq("t1_busy_fall", 32'(bus_if.busy), 32'd0);
        check_eq("t1_addr_hold", bus_if.mem_addr, 32'd1);
        check_eq("t1_data_hold", bus_if.mem_wdata, 32'h9ABCDEF0);
        // Extra bytes after DONE are refused.
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t1_done_ready", 32'(bus_if.in_ready), 32'd0);
            check_eq("t1_done_we", 32'(bus_if.mem_we), 32'd0);
            check_eq("t1_done_run", 32'(bus_if.cpu_run), 32'd1);
        end
        bus_if.in_valid = 1'b0;
        check_eq("t1_writes", 32'(writes_seen - w0), 32'd2);

        // Zero-length header.
        do_reset();
        w0 = writes_seen;
        send_word(32'h0000_0000);
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_err", 32'(bus_if.err), 32'd1);
            check_eq("t2_ready", 32'(bus_if.in_ready), 32'd0);
            check_eq("t2_run", 32'(bus_if.cpu_run), 32'd0);
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        check_eq("t2_writes", 32'(writes_seen - w0), 32'd0);

        // One word past the limit, then exactly the limit.
        do_reset();
        check_eq("t3_err_cleared", 32'(bus_if.err), 32'd0);
        send_word(32'h0000_0401);
        check_eq("t3_err", 32'(bus_if.err), 32'd1);
        check_eq("t3_busy", 32'(bus_if.busy), 32'd0);
        do_reset();
        send_word(32'h0000_0400);
        check_eq("t4_busy", 32'(bus_if.busy), 32'd1);
        check_eq("t4_err", 32'(bus_if.err), 32'd0);
        check_eq("t4_ready", 32'(bus_if.in_ready), 32'd1);

        // Single word with in_valid toggling, byte offered during WRITE.
        do_reset();
        w0 = writes_seen;
        rw = $urandom();
        push_exp(32'd0, rw);
        send_word(32'h0000_0001);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            send_byte(rw[31-8*i -: 8]);
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'hAA;
        check_eq("t5_write_ready", 32'(bus_if.in_ready), 32'd0);
        check_eq("t5_write_we", 32'(bus_if.mem_we), 32'd1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check_eq("t5_run", 32'(bus_if.cpu_run), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("t5_writes", 32'(writes_seen - w0), 32'd1);

        // Asynchronous reset in the middle of word 3 of five.
        do_reset();
        w0 = writes_seen;
        send_word(32'h0000_0005);
        for (int i = 0; i < 3; i++) begin
            rw = $urandom();
            push_exp(32'(i), rw);
            send_word(rw);
        end
        send_byte(8'hDE);
        send_byte(8'hAD);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_exp(32'd0, 32'hCAFEBABE);
        send_word(32'h0000_0001);
        send_word(32'hCAFE_BABE);
        repeat (2) @(negedge clk);
        check_eq("t6_run", 32'(bus_if.cpu_run), 32'd1);
        check_eq("t6_writes", 32'(writes_seen - w0), 32'd4);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("unexpected_writes", 32'(unexpected), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
